// File: rtl/clint_wbs.sv
// Machine timer / software-interrupt block on a Wishbone responder port.
// Single-word accesses, one cycle of latency, at most one access every two cycles.
module clint_wbs #(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter bit          ERR_UNMAPPED = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic          ack_q, err_q;
  logic [31:0]   rdata_q;
  logic          msip, msip_q, mtip_q;
  logic [63:0]   mtime, mtimecmp;
  logic [PW-1:0] presc;

  logic          accept, hit, wr_en, tick;
  logic [31:0]   rd_word;
  logic [63:0]   mtime_nxt, mtimecmp_nxt;
  logic          msip_nxt;
  logic          unused_addr;

  assign unused_addr = ^wbs_addr_i[31:5];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    merge_lanes = old_w;
    for (int unsigned i = 0; i < 4; i++)
      if (sel[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  assign accept = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign wr_en  = accept && wbs_we_i && hit;
  assign tick   = (presc == PW'(TICK_DIV - 1));

  always_comb begin
    hit     = 1'b0;
    rd_word = '0;
    if (wbs_addr_i[1:0] == 2'b00) begin
      case (wbs_addr_i[4:2])
        3'd0: begin hit = 1'b1; rd_word = {31'b0, msip};     end
        3'd2: begin hit = 1'b1; rd_word = mtimecmp[31:0];    end
        3'd3: begin hit = 1'b1; rd_word = mtimecmp[63:32];   end
        3'd4: begin hit = 1'b1; rd_word = mtime[31:0];       end
        3'd5: begin hit = 1'b1; rd_word = mtime[63:32];      end
        default: ;
      endcase
    end
  end

  // A bus write to either mtime word replaces the whole increment for that cycle.
  always_comb begin
    mtime_nxt    = tick ? mtime + 64'd1 : mtime;
    mtimecmp_nxt = mtimecmp;
    msip_nxt     = msip;
    if (wr_en) begin
      case (wbs_addr_i[4:2])
        3'd0: if (wbs_sel_i[0]) msip_nxt = wbs_dat_i[0];
        3'd2: mtimecmp_nxt[31:0]  = merge_lanes(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
        3'd3: mtimecmp_nxt[63:32] = merge_lanes(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
        3'd4: mtime_nxt = {mtime[63:32], merge_lanes(mtime[31:0], wbs_dat_i, wbs_sel_i)};
        3'd5: mtime_nxt = {merge_lanes(mtime[63:32], wbs_dat_i, wbs_sel_i), mtime[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      msip     <= 1'b0;
      msip_q   <= 1'b0;
      mtip_q   <= 1'b0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      presc    <= '0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      msip     <= msip_nxt;
      msip_q   <= msip;
      mtip_q   <= (mtime_nxt >= mtimecmp_nxt);
      presc    <= tick ? '0 : presc + PW'(1);
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= RESP;
            ack_q   <= hit | ~ERR_UNMAPPED;
            err_q   <= ~hit & ERR_UNMAPPED;
            rdata_q <= (hit && !wbs_we_i) ? rd_word : '0;
          end
        end
        RESP: begin
          state   <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = ack_q & wbs_cyc_i;
  assign wbs_err_o   = err_q & wbs_cyc_i;
  assign wbs_dat_o   = wbs_ack_o ? rdata_q : '0;
  assign xint_mtip_o = mtip_q;
  assign xint_msip_o = msip_q;

endmodule

// File: tb/tb_clint_wbs.sv
// Bench for clint_wbs: transaction-level register/timer model checked every cycle,
// plus directed accesses with hand-computed expectations.
module tb_clint_wbs;

  localparam int unsigned TICK_DIV     = 1;
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam bit          ERR_UNMAPPED = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = '0, wdat = '0;
  logic [31:0] dat;
  logic        ack, err, mtip, msip;

  int n_checks = 0;
  int n_fail   = 0;

  clint_wbs #(
    .TICK_DIV(TICK_DIV),
    .MTIMECMP_RST(MTIMECMP_RST),
    .ERR_UNMAPPED(ERR_UNMAPPED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_addr_i(addr), .wbs_dat_i(wdat),
    .wbs_dat_o(dat), .wbs_ack_o(ack), .wbs_err_o(err),
    .xint_mtip_o(mtip), .xint_msip_o(msip)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit [63:0]   m_mtime = '0, m_cmp = MTIMECMP_RST;
  bit          m_msip = 0, m_msip_o = 0, m_mtip = 0;
  bit          m_busy = 0, m_ack = 0, m_err = 0;
  bit [31:0]   m_rdata = '0;
  int unsigned m_ticks = 0;

  function automatic bit [31:0] lanes(input bit [31:0] o, input bit [31:0] n, input bit [3:0] s);
    bit [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [63:0] t, c;
    bit [4:0]  off;
    bit        mapped;
    if (!rst_n) begin
      m_mtime = '0; m_cmp = MTIMECMP_RST; m_msip = 0; m_msip_o = 0; m_mtip = 0;
      m_busy = 0; m_ack = 0; m_err = 0; m_rdata = '0; m_ticks = 0;
    end else begin
      t = m_mtime;
      c = m_cmp;
      m_ticks++;
      if (m_ticks == TICK_DIV) begin
        m_ticks = 0;
        t = t + 1;
      end
      m_msip_o = m_msip;
      if (m_busy) begin
        m_busy = 0; m_ack = 0; m_err = 0; m_rdata = '0;
      end else if (cyc && stb) begin
        off    = addr[4:0];
        mapped = off inside {5'h00, 5'h08, 5'h0C, 5'h10, 5'h14};
        m_busy  = 1;
        m_err   = !mapped && ERR_UNMAPPED;
        m_ack   = !m_err;
        m_rdata = '0;
        if (mapped && !we) begin
          case (off)
            5'h00: m_rdata = {31'b0, m_msip};
            5'h08: m_rdata = m_cmp[31:0];
            5'h0C: m_rdata = m_cmp[63:32];
            5'h10: m_rdata = m_mtime[31:0];
            default: m_rdata = m_mtime[63:32];
          endcase
        end
        if (mapped && we) begin
          case (off)
            5'h00: if (sel[0]) m_msip = wdat[0];
            5'h08: c[31:0]  = lanes(m_cmp[31:0], wdat, sel);
            5'h0C: c[63:32] = lanes(m_cmp[63:32], wdat, sel);
            5'h10: t = {m_mtime[63:32], lanes(m_mtime[31:0], wdat, sel)};
            default: t = {lanes(m_mtime[63:32], wdat, sel), m_mtime[31:0]};
          endcase
        end
      end
      m_mtime = t;
      m_cmp   = c;
      m_mtip  = (t >= c);
    end
  end

  always @(negedge clk) begin
    bit e_ack, e_err;
    e_ack = m_ack & cyc;
    e_err = m_err & cyc;
    check("cyc_ack",  ack,  e_ack);
    check("cyc_err",  err,  e_err);
    check("cyc_dat",  dat,  e_ack ? m_rdata : 32'h0);
    check("cyc_mtip", mtip, m_mtip);
    check("cyc_msip", msip, m_msip_o);
  end

  // ---------------- directed ----------------
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output logic g_ack, output logic g_err, output int lat);
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; addr = a; sel = s; wdat = d;
    g_ack = 0; g_err = 0; rd = '0; lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack || err) begin
        g_ack = ack; g_err = err; rd = dat; lat = i;
        break;
      end
    end
    check("resp_seen", g_ack | g_err, 1);
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; sel = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ga, ge;
    int          lat, k;

    rst_n = 0;
    #22 rst_n = 1;

    // reset values through the bus
    bus(0, 32'h08, 4'hF, 0, rd, ga, ge, lat);
    check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
    check("rst_lat", lat, 1);
    check("rst_ack", {ga, ge}, 2'b10);
    bus(0, 32'h0C, 4'hF, 0, rd, ga, ge, lat);
    check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
    check("rst_mtip", mtip, 0);
    check("rst_msip", msip, 0);

    // software interrupt
    bus(1, 32'h00, 4'hF, 32'h1, rd, ga, ge, lat);
    check("msip_set", msip, 1);
    bus(0, 32'h00, 4'hF, 0, rd, ga, ge, lat);
    check("msip_read", rd, 32'h1);
    bus(1, 32'h00, 4'hF, 32'h0, rd, ga, ge, lat);
    check("msip_clr", msip, 0);

    // errors and partial write
    bus(0, 32'h18, 4'hF, 0, rd, ga, ge, lat);
    check("err_18", {ga, ge, rd}, {2'b01, 32'h0});
    bus(0, 32'h02, 4'hF, 0, rd, ga, ge, lat);
    check("err_02", {ga, ge, rd}, {2'b01, 32'h0});
    bus(1, 32'h1C, 4'hF, 32'h1234_5678, rd, ga, ge, lat);
    check("err_wr_1c", ge, 1);
    bus(1, 32'h08, 4'b0010, 32'hAABB_CCDD, rd, ga, ge, lat);
    bus(0, 32'h08, 4'hF, 0, rd, ga, ge, lat);
    check("sel_byte1", rd, 32'hFFFF_CCFF);

    // low-to-high carry
    bus(1, 32'h14, 4'hF, 32'h0, rd, ga, ge, lat);
    bus(1, 32'h10, 4'hF, 32'hFFFF_FFFE, rd, ga, ge, lat);
    repeat (3) @(posedge clk);
    bus(0, 32'h14, 4'hF, 0, rd, ga, ge, lat);
    check("carry_hi", rd, 32'h1);
    bus(0, 32'h10, 4'hF, 0, rd, ga, ge, lat);
    check("carry_lo_small", rd < 32'h40, 1);

    // timer compare
    bus(1, 32'h08, 4'hF, 32'h20, rd, ga, ge, lat);
    bus(1, 32'h0C, 4'hF, 32'h0, rd, ga, ge, lat);
    bus(1, 32'h14, 4'hF, 32'h0, rd, ga, ge, lat);
    bus(1, 32'h10, 4'hF, 32'h1C, rd, ga, ge, lat);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mtip) begin k = i; break; end
    end
    check("mtip_rise_at_20", k, 4);
    bus(1, 32'h0C, 4'hF, 32'h1, rd, ga, ge, lat);
    check("mtip_fall", mtip, 0);

    // cyc dropped during response: no ack, write still commits
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 1; addr = 32'h0; sel = 4'hF; wdat = 32'h1;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    check("drop_no_ack", {ack, err}, 2'b00);
    @(negedge clk);
    check("drop_commit", msip, 1);

    // async reset in the response cycle
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; addr = 32'h10; sel = 4'hF;
    @(posedge clk); #1;
    check("pre_rst_ack", ack, 1);
    #2 rst_n = 0;
    #1;
    check("rst_ack_drop", ack, 0);
    check("rst_msip", msip, 0);
    cyc = 0; stb = 0;
    @(negedge clk); #2 rst_n = 1;
    bus(0, 32'h08, 4'hF, 0, rd, ga, ge, lat);
    check("rst2_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(0, 32'h0C, 4'hF, 0, rd, ga, ge, lat);
    check("rst2_cmp_hi", rd, 32'hFFFF_FFFF);
    bus(0, 32'h00, 4'hF, 0, rd, ga, ge, lat);
    check("rst2_msip", rd, 32'h0);
    bus(0, 32'h14, 4'hF, 0, rd, ga, ge, lat);
    check("rst2_mtime_hi", rd, 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
